// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD converter (iterative double dabble, one bit per clock) feeding a
// display register that is scanned out one digit at a time with leading-zero blanking.
module bcd_digit_scanner #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [DATA_W-1:0]           Data,
  input  logic                        LOAD,
  input  logic                        BLANK_EN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        OVF,
  output logic [$clog2(DIGITS)-1:0]   SEL,
  output logic [3:0]                  Y,
  output logic                        BLANKED
);

  localparam int unsigned SEL_W = $clog2(DIGITS);
  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CMP_W = (DATA_W > 64) ? DATA_W : 64;

  // 10^n as a 64-bit elaboration-time constant
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [CMP_W-1:0]     MAX_VAL  = CMP_W'(pow10(DIGITS) - 64'd1);
  localparam logic [CNT_W-1:0]     LAST_IT  = CNT_W'(DATA_W - 1);
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(DIGITS - 1);
  localparam logic [BCD_W-1:0]     ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               data_ovf;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [3:0]         y_q, y_d;
  logic               blanked_q, blanked_d;
  logic               pre_tc;
  logic [3:0]         digit_c [DIGITS];
  logic [DIGITS-1:0]  blank_vec;
  logic               zero_run;

  assign data_ovf = CMP_W'(Data) > MAX_VAL;

  // Add-3 correction applied to every nibble before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = 4'(bcd_q[4*i +: 4] + 4'd3);
    end
  end

  // Conversion FSM: next state and datapath
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          bin_d      = Data;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = data_ovf;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_IT) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = ovf_pend_q ? ALL_NINE : bcd_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CONV);
  end

  // Scan prescaler, digit select and blanked output digit
  always_comb begin
    pre_tc = (pre_q == PRE_LAST);
    pre_d  = pre_tc ? '0 : PRE_W'(pre_q + 1'b1);
    sel_d  = sel_q;
    if (pre_tc) sel_d = (sel_q == SEL_LAST) ? '0 : SEL_W'(sel_q + 1'b1);

    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      digit_c[i] = disp_q[4*i +: 4];
      zero_run   = zero_run & (disp_q[4*i +: 4] == 4'd0);
      if (i > 0) blank_vec[i] = BLANK_EN & zero_run;
    end

    blanked_d = blank_vec[sel_d];
    y_d       = blanked_d ? 4'd0 : digit_c[sel_d];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pre_q      <= '0;
      sel_q      <= '0;
      y_q        <= '0;
      blanked_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pre_q      <= pre_d;
      sel_q      <= sel_d;
      y_q        <= y_d;
      blanked_q  <= blanked_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign OVF     = ovf_q;
  assign SEL     = sel_q;
  assign Y       = y_q;
  assign BLANKED = blanked_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Randomized self-checking bench for bcd_digit_scanner with a decimal-arithmetic reference model.
module tb_bcd_digit_scanner;

  localparam int unsigned DATA_W   = 10;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned SCAN_DIV = 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic              load;
  logic              blank_en;
  logic              busy, done, ovf, blanked;
  logic [1:0]        sel;
  logic [3:0]        y;

  int checks = 0;
  int errors = 0;
  int unsigned ecount;

  bcd_digit_scanner #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(clk), .RST_N(rst_n), .Data(data), .LOAD(load), .BLANK_EN(blank_en),
    .BUSY(busy), .DONE(done), .OVF(ovf), .SEL(sel), .Y(y), .BLANKED(blanked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges seen since reset release; the scan position follows from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  function automatic int unsigned shown(input int unsigned v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic int unsigned pw10(input int unsigned s);
    int unsigned p = 1;
    for (int unsigned k = 0; k < s; k++) p = p * 10;
    return p;
  endfunction

  function automatic bit exp_blank(input int unsigned v, input int unsigned s, input bit ben);
    return ben && (s > 0) && (shown(v) < pw10(s));
  endfunction

  function automatic logic [3:0] exp_y(input int unsigned v, input int unsigned s, input bit ben);
    if (exp_blank(v, s, ben)) return 4'd0;
    return 4'((shown(v) / pw10(s)) % 10);
  endfunction

  function automatic int unsigned exp_sel();
    return (ecount / SCAN_DIV) % DIGITS;
  endfunction

  // Start a conversion and wait (bounded) for DONE; returns one cycle after DONE
  task automatic convert(input int unsigned v, output bit ok);
    @(negedge clk);
    data = DATA_W'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; data = '0; blank_en = 1'b0;
    #23;
    checks++;
    if ({busy, done, ovf, sel, y, blanked} !== 9'd0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b ovf=%b sel=%0d y=%0d blanked=%b want all 0",
               busy, done, ovf, sel, y, blanked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== 2'(exp_sel()) || y !== 4'd0 || blanked !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan cycle %0d got sel=%0d y=%0d blanked=%b want sel=%0d y=0 blanked=0",
                 c, sel, y, blanked, exp_sel());
      end
    end
  endtask

  task automatic test_conversion();
    @(negedge clk);
    data = 10'd937;
    load = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (busy !== (k <= 9) || done !== (k == 11)) begin
        errors++;
        $display("FAIL conv_timing after edge t+%0d got busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, (k <= 9), (k == 11));
      end
      if (k <= 11) begin
        checks++;
        if (y !== exp_y(0, exp_sel(), 1'b0)) begin
          errors++;
          $display("FAIL conv_hold after edge t+%0d got y=%0d want 0", k, y);
        end
      end
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL conv_ovf got %b want 0", ovf);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (sel !== 2'(exp_sel()) || y !== exp_y(937, exp_sel(), 0) || blanked !== 1'b0) begin
        errors++;
        $display("FAIL conv_scan got sel=%0d y=%0d blanked=%b want sel=%0d y=%0d blanked=0",
                 sel, y, blanked, exp_sel(), exp_y(937, exp_sel(), 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int unsigned vals [3] = '{1023, 999, 0};
    bit ok;
    blank_en = 1'b0;
    foreach (vals[n]) begin
      convert(vals[n], ok);
      checks++;
      if (!ok || ovf !== (vals[n] > 999)) begin
        errors++;
        $display("FAIL ovf_flag value %0d got done_seen=%b ovf=%b want done_seen=1 ovf=%b",
                 vals[n], ok, ovf, (vals[n] > 999));
      end
      for (int c = 0; c < 12; c++) begin
        checks++;
        if (sel !== 2'(exp_sel()) || y !== exp_y(vals[n], exp_sel(), 0) || blanked !== 1'b0) begin
          errors++;
          $display("FAIL ovf_scan value %0d got sel=%0d y=%0d blanked=%b want sel=%0d y=%0d",
                   vals[n], sel, y, blanked, exp_sel(), exp_y(vals[n], exp_sel(), 0));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blanking();
    int unsigned vals [4] = '{5, 105, 0, 0};
    bit          bens [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit ok;
    foreach (vals[n]) begin
      blank_en = bens[n];
      convert(vals[n], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL blank_done value %0d got no DONE want DONE", vals[n]);
      end
      for (int c = 0; c < 12; c++) begin
        checks++;
        if (sel !== 2'(exp_sel()) || y !== exp_y(vals[n], exp_sel(), bens[n]) ||
            blanked !== exp_blank(vals[n], exp_sel(), bens[n])) begin
          errors++;
          $display("FAIL blank_scan value %0d en=%b got sel=%0d y=%0d blanked=%b want sel=%0d y=%0d blanked=%b",
                   vals[n], bens[n], sel, y, blanked, exp_sel(),
                   exp_y(vals[n], exp_sel(), bens[n]), exp_blank(vals[n], exp_sel(), bens[n]));
        end
        @(negedge clk);
      end
    end
    blank_en = 1'b0;
  endtask

  task automatic test_handshake();
    bit ok;
    @(negedge clk);
    data = 10'd123;
    load = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      load = (k == 2) || (k == 10) || (k == 11);
      data = load ? 10'd456 : 10'd123;
      if (k == 3 || k == 11) begin
        checks++;
        if (busy !== (k == 3) || done !== (k == 11)) begin
          errors++;
          $display("FAIL hs_ignore after edge t+%0d got busy=%b done=%b want busy=%b done=%b",
                   k, busy, done, (k == 3), (k == 11));
        end
      end
      if (k == 12) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL hs_accept got busy=%b want 1", busy);
        end
      end
    end
    load = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (sel !== 2'(exp_sel()) || y !== exp_y(123, exp_sel(), 0)) begin
        errors++;
        $display("FAIL hs_scan123 got sel=%0d y=%0d want sel=%0d y=%0d",
                 sel, y, exp_sel(), exp_y(123, exp_sel(), 0));
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hs_done got no DONE for second load want DONE");
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (sel !== 2'(exp_sel()) || y !== exp_y(456, exp_sel(), 0)) begin
        errors++;
        $display("FAIL hs_scan456 got sel=%0d y=%0d want sel=%0d y=%0d",
                 sel, y, exp_sel(), exp_y(456, exp_sel(), 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit seen_done;
    @(negedge clk);
    data = 10'd777;
    load = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      load = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, sel, y, blanked} !== 9'd0) begin
      errors++;
      $display("FAIL abort_async got busy=%b done=%b ovf=%b sel=%0d y=%0d blanked=%b want all 0",
               busy, done, ovf, sel, y, blanked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      checks++;
      if (sel !== 2'(exp_sel()) || y !== 4'd0 || blanked !== 1'b0) begin
        errors++;
        $display("FAIL abort_scan got sel=%0d y=%0d blanked=%b want sel=%0d y=0 blanked=0",
                 sel, y, blanked, exp_sel());
      end
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL abort_quiet got busy/done activity=1 want 0");
    end
    convert(777, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_reload got no DONE want DONE");
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (sel !== 2'(exp_sel()) || y !== exp_y(777, exp_sel(), 0)) begin
        errors++;
        $display("FAIL abort_rescan got sel=%0d y=%0d want sel=%0d y=%0d",
                 sel, y, exp_sel(), exp_y(777, exp_sel(), 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int unsigned v;
    bit ok;
    bit ben;
    for (int n = 0; n < 12; n++) begin
      v   = (n % 4 == 3) ? $urandom_range(1023, 1000) : $urandom_range(1023, 0);
      ben = 1'($urandom_range(1, 0));
      blank_en = ben;
      convert(v, ok);
      checks++;
      if (!ok || ovf !== (v > 999)) begin
        errors++;
        $display("FAIL rand_done value %0d got done_seen=%b ovf=%b want done_seen=1 ovf=%b",
                 v, ok, ovf, (v > 999));
      end
      for (int c = 0; c < 12; c++) begin
        checks++;
        if (sel !== 2'(exp_sel()) || y !== exp_y(v, exp_sel(), ben) ||
            blanked !== exp_blank(v, exp_sel(), ben)) begin
          errors++;
          $display("FAIL rand_scan value %0d en=%b got sel=%0d y=%0d blanked=%b want sel=%0d y=%0d blanked=%b",
                   v, ben, sel, y, blanked, exp_sel(), exp_y(v, exp_sel(), ben),
                   exp_blank(v, exp_sel(), ben));
        end
        @(negedge clk);
      end
    end
    blank_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_overflow();
    test_blanking();
    test_handshake();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
